rally_ctrl: RTL and testbench

RALLY_CTRL -- requirements
Module: rally_ctrl

---
 rtl/pingpong_pkg.sv | 42 ++++
 rtl/ball_integrator.sv | 41 ++++
 rtl/rally_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rally_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the rally controller: FSM encoding, location/velocity
// field layout, screen geometry and edge-detector codes.
package pingpong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_CHECK  = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    // ball_location = {y, x}, ball_velocity = {signed vy, signed vx}
    localparam int COORD_W   = 11;
    localparam int LOC_W     = 2 * COORD_W;
    localparam int LOC_X_LSB = 0;
    localparam int LOC_Y_LSB = COORD_W;
    localparam int VCOMP_W   = 16;
    localparam int VEL_W     = 2 * VCOMP_W;
    localparam int VEL_X_LSB = 0;
    localparam int VEL_Y_LSB = VCOMP_W;
    localparam int POS_W     = 13;
    localparam int SCORE_W   = 4;

    localparam int X_MAX    = 1280;
    localparam int Y_MAX    = 790;
    localparam int CENTER_X = 640;
    localparam int CENTER_Y = 395;

    localparam logic [LOC_W-1:0] LOC_CENTER = {COORD_W'(CENTER_Y), COORD_W'(CENTER_X)};

    localparam logic [1:0] EDG_NONE  = 2'b00;
    localparam logic [1:0] EDG_RIGHT = 2'b01;
    localparam logic [1:0] EDG_LEFT  = 2'b10;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s < lim) ? s + SCORE_W'(1) : lim;
    endfunction

endpackage

// File: rtl/ball_integrator.sv
// Combinational next-position adder: location + velocity in 13-bit signed
// arithmetic, each axis clamped to the playfield plus one pixel of overshoot.
module ball_integrator
    import pingpong_pkg::*;
(
    input  logic [LOC_W-1:0] loc,
    input  logic [VEL_W-1:0] vel,
    output logic [LOC_W-1:0] next_loc
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int LOC_LSB = (gi == 0) ? LOC_X_LSB : LOC_Y_LSB;
            localparam int VEL_LSB = (gi == 0) ? VEL_X_LSB : VEL_Y_LSB;
            // One pixel past the edge so the edge detector always sees the exit
            localparam logic signed [POS_W-1:0] LIMIT =
                (gi == 0) ? POS_W'(X_MAX + 1) : POS_W'(Y_MAX + 1);

            logic signed [POS_W-1:0] pos;
            logic signed [POS_W-1:0] spd;
            logic signed [POS_W-1:0] sum;
            logic [COORD_W-1:0]      clamped;

            assign pos = {{(POS_W-COORD_W){1'b0}}, loc[LOC_LSB +: COORD_W]};
            assign spd = vel[VEL_LSB +: POS_W];
            assign sum = pos + spd;

            always_comb begin
                clamped = sum[COORD_W-1:0];
                if (sum < 0) begin
                    clamped = '0;
                end else if (sum > LIMIT) begin
                    clamped = LIMIT[COORD_W-1:0];
                end
            end

            assign next_loc[LOC_LSB +: COORD_W] = clamped;
        end
    endgenerate

endmodule

// File: rtl/rally_ctrl.sv
// Pong rally controller: serve, ball flight, collision/edge resolution, scoring.
// Optional macro RALLY_SPEEDUP_EN: each accepted paddle hit raises |vx| by 1 (max 15).
module rally_ctrl
    import pingpong_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int POINT_FRAMES = 60,
    parameter int HIT_COOLDOWN = 8,
    parameter int SERVE_VX     = 4,
    parameter int SERVE_VY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 serve_btn,
    input  logic                 collide,
    input  logic [1:0]           edg,
    output logic [LOC_W-1:0]     ball_location,
    output logic [VEL_W-1:0]     ball_velocity,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r,
    output logic [2:0]           state,
    output logic                 game_over
);

    localparam int CD_W = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;
    localparam int PC_W = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

    localparam logic [CD_W-1:0]           CD_LOAD    = CD_W'(HIT_COOLDOWN);
    localparam logic [PC_W-1:0]           PC_LAST    = PC_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0]        WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic signed [VCOMP_W-1:0] SERVE_VX_S = VCOMP_W'(SERVE_VX);
    localparam logic signed [VCOMP_W-1:0] SERVE_VY_S = VCOMP_W'(SERVE_VY);

    state_t               state_reg, state_next;
    logic [LOC_W-1:0]     loc_reg, loc_next, loc_integ;
    logic [VEL_W-1:0]     vel_reg, vel_next;
    logic [SCORE_W-1:0]   score_l_reg, score_l_next;
    logic [SCORE_W-1:0]   score_r_reg, score_r_next;
    logic [CD_W-1:0]      cooldown_reg, cooldown_next;
    logic [PC_W-1:0]      point_cnt_reg, point_cnt_next;
    logic                 pending_reg, pending_next;
    logic                 serve_dir_reg, serve_dir_next;
    logic                 game_over_reg, game_over_next;

    logic                        tick_eff;
    logic signed [VCOMP_W-1:0]   vx_cur;
    logic signed [VCOMP_W-1:0]   vx_bounce;

    ball_integrator u_integ (
        .loc      (loc_reg),
        .vel      (vel_reg),
        .next_loc (loc_integ)
    );

    // Horizontal velocity after an accepted paddle hit
`ifdef RALLY_SPEEDUP_EN
    localparam logic signed [VCOMP_W-1:0] VX_CAP = 16'sd15;
    logic signed [VCOMP_W-1:0] vx_mag;

    always_comb begin
        vx_cur = signed'(vel_reg[VEL_X_LSB +: VCOMP_W]);
        vx_mag = vx_cur[VCOMP_W-1] ? -vx_cur : vx_cur;
        if (vx_mag < VX_CAP) begin
            vx_mag = vx_mag + 16'sd1;
        end else begin
            vx_mag = VX_CAP;
        end
        vx_bounce = vx_cur[VCOMP_W-1] ? vx_mag : -vx_mag;
    end
`else
    always_comb begin
        vx_cur    = signed'(vel_reg[VEL_X_LSB +: VCOMP_W]);
        vx_bounce = -vx_cur;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            loc_reg       <= LOC_CENTER;
            vel_reg       <= '0;
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            cooldown_reg  <= '0;
            point_cnt_reg <= '0;
            pending_reg   <= 1'b0;
            serve_dir_reg <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            loc_reg       <= loc_next;
            vel_reg       <= vel_next;
            score_l_reg   <= score_l_next;
            score_r_reg   <= score_r_next;
            cooldown_reg  <= cooldown_next;
            point_cnt_reg <= point_cnt_next;
            pending_reg   <= pending_next;
            serve_dir_reg <= serve_dir_next;
            game_over_reg <= game_over_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        loc_next       = loc_reg;
        vel_next       = vel_reg;
        score_l_next   = score_l_reg;
        score_r_next   = score_r_reg;
        cooldown_next  = cooldown_reg;
        point_cnt_next = point_cnt_reg;
        pending_next   = pending_reg;
        serve_dir_next = serve_dir_reg;
        game_over_next = game_over_reg;
        tick_eff       = frame_tick | pending_reg;

        case (state_reg)
            ST_IDLE: begin
                if (serve_btn) begin
                    state_next = ST_SERVE;
                end
            end

            ST_SERVE: begin
                loc_next                          = LOC_CENTER;
                vel_next[VEL_X_LSB +: VCOMP_W]    = serve_dir_reg ? -SERVE_VX_S : SERVE_VX_S;
                vel_next[VEL_Y_LSB +: VCOMP_W]    = SERVE_VY_S;
                serve_dir_next                    = ~serve_dir_reg;
                cooldown_next                     = '0;
                if (frame_tick) begin
                    pending_next = 1'b1;
                end
                state_next = ST_FLIGHT;
            end

            ST_FLIGHT: begin
                if (tick_eff) begin
                    loc_next     = loc_integ;
                    pending_next = 1'b0;
                    if (cooldown_reg != '0) begin
                        cooldown_next = cooldown_reg - CD_W'(1);
                    end
                    state_next = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (frame_tick) begin
                    pending_next = 1'b1;
                end
                state_next = ST_FLIGHT;
                // A collide still inside the cooldown window falls through to the edge test
                if (collide && (cooldown_reg == '0)) begin
                    vel_next[VEL_X_LSB +: VCOMP_W] = vx_bounce;
                    cooldown_next                  = CD_LOAD;
                end else if (edg == EDG_RIGHT || edg == EDG_LEFT) begin
                    if (edg == EDG_RIGHT) begin
                        score_l_next = sat_inc(score_l_reg, WIN_S);
                    end else begin
                        score_r_next = sat_inc(score_r_reg, WIN_S);
                    end
                    vel_next       = '0;
                    pending_next   = 1'b0;
                    point_cnt_next = '0;
                    state_next     = ST_POINT;
                end
            end

            ST_POINT: begin
                vel_next = '0;
                if (frame_tick) begin
                    if (point_cnt_reg == PC_LAST) begin
                        point_cnt_next = '0;
                        if (score_l_reg == WIN_S || score_r_reg == WIN_S) begin
                            state_next     = ST_OVER;
                            game_over_next = 1'b1;
                        end else begin
                            state_next = ST_SERVE;
                        end
                    end else begin
                        point_cnt_next = point_cnt_reg + PC_W'(1);
                    end
                end
            end

            ST_OVER: begin
                if (serve_btn) begin
                    score_l_next   = '0;
                    score_r_next   = '0;
                    game_over_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ball_location = loc_reg;
    assign ball_velocity = vel_reg;
    assign score_l       = score_l_reg;
    assign score_r       = score_r_reg;
    assign state         = state_reg;
    assign game_over     = game_over_reg;

endmodule

// File: tb/tb_rally_ctrl.sv
// Scoreboard bench for rally_ctrl: stimulus queues the expected snapshot for
// every state change, a monitor compares whenever the DUT changes state.
module tb_rally_ctrl;
    import pingpong_pkg::*;

    localparam int PF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        serve_btn = 1'b0;
    logic        collide = 1'b0;
    logic [1:0]  edg = 2'b00;
    logic [21:0] ball_location;
    logic [31:0] ball_velocity;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic [2:0]  state;
    logic        game_over;

    rally_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .serve_btn     (serve_btn),
        .collide       (collide),
        .edg           (edg),
        .ball_location (ball_location),
        .ball_velocity (ball_velocity),
        .score_l       (score_l),
        .score_r       (score_r),
        .state         (state),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        bit          chk_ball;
        logic [21:0] loc;
        logic [31:0] vel;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        go;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Bench-side picture of the rally
    int x, y, vx, vy, sl_m, sr_m;
    bit sdir;

    function automatic logic [21:0] mkloc(input int xx, input int yy);
        return {11'(yy), 11'(xx)};
    endfunction

    function automatic logic [31:0] mkvel(input int vxx, input int vyy);
        return {16'(vyy), 16'(vxx)};
    endfunction

    function automatic int bounce(input int v);
`ifdef RALLY_SPEEDUP_EN
        int m;
        m = (v < 0) ? -v : v;
        m = (m >= 15) ? 15 : m + 1;
        return (v < 0) ? m : -m;
`else
        return -v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] st, input bit chk, input int pvx, input int pvy,
                        input logic go);
        exp_t e;
        e.st       = st;
        e.chk_ball = chk;
        e.loc      = mkloc(x, y);
        e.vel      = mkvel(pvx, pvy);
        e.sl       = 4'(sl_m);
        e.sr       = 4'(sr_m);
        e.go       = go;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic serve_model();
        x    = 640;
        y    = 395;
        vx   = sdir ? -4 : 4;
        vy   = 2;
        sdir = ~sdir;
    endtask

    task automatic press_serve();
        push(ST_SERVE, 1'b0, 0, 0, 1'b0);
        serve_model();
        push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        serve_btn = 1'b1;
        step(1);
        serve_btn = 1'b0;
        check("serve_entered", 32'(state), 32'(ST_SERVE));
        step(1);
        check("serve_one_cycle", 32'(state), 32'(ST_FLIGHT));
    endtask

    // One frame from FLIGHT: tick, then collide/edg presented during CHECK
    task automatic fly(input logic col, input logic [1:0] e, input bit hit);
        x = x + vx;
        y = y + vy;
        x = (x < 0) ? 0 : (x > 1281) ? 1281 : x;
        y = (y < 0) ? 0 : (y > 791) ? 791 : y;
        push(ST_CHECK, 1'b1, vx, vy, 1'b0);
        if (hit) begin
            vx = bounce(vx);
            push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        end else if (e == 2'b01) begin
            sl_m++;
            push(ST_POINT, 1'b1, 0, 0, 1'b0);
        end else if (e == 2'b10) begin
            sr_m++;
            push(ST_POINT, 1'b1, 0, 0, 1'b0);
        end else begin
            push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        end
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        collide    = col;
        edg        = e;
        step(1);
        collide    = 1'b0;
        edg        = 2'b00;
    endtask

    task automatic run_point(input bit to_over);
        if (to_over) begin
            push(ST_OVER, 1'b1, 0, 0, 1'b1);
        end else begin
            push(ST_SERVE, 1'b0, 0, 0, 1'b0);
            serve_model();
            push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        end
        frame_tick = 1'b1;
        step(PF - 1);
        check("point_hold", 32'(state), 32'(ST_POINT));
        step(1);
        frame_tick = 1'b0;
        check("point_exit", 32'(state), to_over ? 32'(ST_OVER) : 32'(ST_SERVE));
        if (!to_over) step(1);
    endtask

    // Monitor: one comparison set per DUT state change
    initial begin : monitor
        exp_t       e;
        logic [2:0] prev;
        prev = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = state;
            end else if (state !== prev) begin
                prev = state;
                $display("[%0t] state %0d loc (%0d,%0d) vel (%0d,%0d) score %0d:%0d over %0b",
                         $time, state, ball_location[10:0], ball_location[21:11],
                         $signed(ball_velocity[15:0]), $signed(ball_velocity[31:16]),
                         score_l, score_r, game_over);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition: got state %0d, required no change", state);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_state", 32'(state), 32'(e.st));
                    if (e.chk_ball) begin
                        check("mon_location", 32'(ball_location), 32'(e.loc));
                        check("mon_velocity", ball_velocity, e.vel);
                    end
                    check("mon_score_l", 32'(score_l), 32'(e.sl));
                    check("mon_score_r", 32'(score_r), 32'(e.sr));
                    check("mon_game_over", 32'(game_over), 32'(e.go));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        x = 640; y = 395; vx = 0; vy = 0; sl_m = 0; sr_m = 0; sdir = 1'b0;

        step(3);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_location", 32'(ball_location), 32'(mkloc(640, 395)));
        check("rst_velocity", ball_velocity, 32'd0);
        check("rst_scores", 32'({score_l, score_r}), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_without_btn", 32'(state), 32'(ST_IDLE));

        // Serve 1: (640,395) vx=+4 vy=+2; three plain frames, serve_btn ignored mid-rally
        press_serve();
        fly(1'b0, 2'b00, 1'b0);
        serve_btn = 1'b1;
        fly(1'b0, 2'b00, 1'b0);
        serve_btn = 1'b0;
        fly(1'b0, 2'b00, 1'b0);
        check("loc_after_3_frames", 32'(ball_location), 32'(mkloc(652, 401)));

        // Hit, ignored hit inside cooldown, accepted hit 8 frames after the first
        fly(1'b1, 2'b00, 1'b1);
        fly(1'b0, 2'b00, 1'b0);
        fly(1'b1, 2'b00, 1'b0);
        repeat (5) fly(1'b0, 2'b00, 1'b0);
        fly(1'b1, 2'b00, 1'b1);
        fly(1'b0, 2'b11, 1'b0);
        fly(1'b0, 2'b01, 1'b0);
        check("score_l_after_point", 32'(score_l), 32'd1);
        run_point(1'b0);
        check("serve2_velocity", ball_velocity, mkvel(-4, 2));

        // Tick arriving during CHECK is held and consumed on the next FLIGHT cycle
        x = x + vx; y = y + vy;
        push(ST_CHECK, 1'b1, vx, vy, 1'b0);
        push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        x = x + vx; y = y + vy;
        push(ST_CHECK, 1'b1, vx, vy, 1'b0);
        push(ST_FLIGHT, 1'b1, vx, vy, 1'b0);
        frame_tick = 1'b1;
        step(2);
        frame_tick = 1'b0;
        step(2);
        check("pending_tick_loc", 32'(ball_location), 32'(mkloc(632, 399)));

        // Right player scores 11 points; the last one ends the game
        for (int i = 1; i <= 11; i++) begin
            fly(1'b0, 2'b10, 1'b0);
            run_point(i == 11);
        end
        check("final_score_r", 32'(score_r), 32'd11);
        frame_tick = 1'b1;
        step(5);
        frame_tick = 1'b0;
        check("over_ignores_tick", 32'(state), 32'(ST_OVER));
        sl_m = 0;
        sr_m = 0;
        push(ST_IDLE, 1'b1, 0, 0, 1'b0);
        serve_btn = 1'b1;
        step(1);
        serve_btn = 1'b0;
        check("over_to_idle", 32'(state), 32'(ST_IDLE));
        frame_tick = 1'b1;
        step(3);
        frame_tick = 1'b0;
        check("idle_ignores_tick", 32'(state), 32'(ST_IDLE));

        // Reset in the middle of a POINT countdown
        press_serve();
        fly(1'b0, 2'b01, 1'b0);
        frame_tick = 1'b1;
        step(20);
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        check("midrst_scores", 32'({score_l, score_r}), 32'd0);
        check("midrst_location", 32'(ball_location), 32'(mkloc(640, 395)));
        check("midrst_velocity", ball_velocity, 32'd0);
        frame_tick = 1'b0;
        step(2);
        rst = 1'b0;
        x = 640; y = 395; sl_m = 0; sr_m = 0; sdir = 1'b0;
        step(1);
        press_serve();
        check("serve_dir_after_rst", ball_velocity, mkvel(4, 2));

        // Long flight to both saturation limits
        repeat (200) fly(1'b0, 2'b00, 1'b0);
        check("saturated_location", 32'(ball_location), 32'(mkloc(1281, 791)));

        step(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
